coin_scheduler: RTL and testbench

Central controller for all coin sprites in a level. It collects per-pixel player/coin overlap flags during each frame and commits them once per frame tick. A serial commit FSM drives each coin's alive flag, keeps the collected-coin score and emits a collection pulse. It also owns the shared front/side/back animation phase, so every coin instance spins in lockstep and reads the same sprite ROM bank.

---
 rtl/coin_scheduler.sv | 162 ++++++++++++++++
 tb/tb_coin_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/coin_scheduler.sv
// Coin scheduler: gathers per-coin overlap hits each frame, commits them serially
// once per frame tick, keeps a saturating score and drives the shared spin phase.
module coin_scheduler #(
  parameter int NUM_COINS    = 8,
  parameter int SCORE_W      = 10,
  parameter int PHASE_FRAMES = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic                 level_restart,
  input  logic [NUM_COINS-1:0] mario_hit,
  output logic [NUM_COINS-1:0] coin_alive,
  output logic [1:0]           coin_phase,
  output logic [SCORE_W-1:0]   score,
  output logic                 coin_event,
  output logic                 all_collected
);

  localparam int IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
  localparam int FC_W  = (PHASE_FRAMES > 1) ? $clog2(PHASE_FRAMES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COINS - 1);
  localparam logic [FC_W-1:0]  LAST_FC  = FC_W'(PHASE_FRAMES - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                 state_q, state_d;
  logic                   sync_now_q, sync_prev_q;
  logic                   tick_q, tick_d;
  logic                   sticky_q, sticky_d;
  logic [NUM_COINS-1:0]   alive_q, alive_d;
  logic [NUM_COINS-1:0]   pending_q, pending_d;
  logic [NUM_COINS-1:0]   commit_q, commit_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [FC_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic [1:0]             phase_q, phase_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic                   event_q, event_d;

  logic [NUM_COINS-1:0]   new_hits;
  logic [NUM_COINS-1:0]   sel;

  assign new_hits = mario_hit & alive_q;
  assign sel      = NUM_COINS'(1) << idx_q;
  assign tick_d   = sync_now_q & ~sync_prev_q;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (level_restart) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (tick_q || sticky_q) state_d = SCAN;
        SCAN:    if (idx_q == LAST_IDX)  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next-state logic
  always_comb begin
    // NOTE: every target gets a default first, so no path can leave one unassigned and infer a latch.
    alive_d     = alive_q;
    pending_d   = pending_q | new_hits;
    commit_d    = commit_q;
    idx_d       = idx_q;
    sticky_d    = sticky_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    score_d     = score_q;
    event_d     = 1'b0;

    if (tick_q) begin
      if (frame_cnt_q == LAST_FC) begin
        frame_cnt_d = '0;
        phase_d     = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (tick_q || sticky_q) begin
          commit_d  = pending_q | new_hits;
          pending_d = '0;
          idx_d     = '0;
          sticky_d  = 1'b0;
        end
      end
      SCAN: begin
        if (tick_q) sticky_d = 1'b1;
        // Alive re-check: a coin already collected is never counted twice.
        if (|(commit_q & alive_q & sel)) begin
          alive_d = alive_q & ~sel;
          event_d = 1'b1;
          if (score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
        end
        idx_d = idx_q + IDX_W'(1);
      end
      default: ;
    endcase

    if (level_restart) begin
      alive_d     = '1;
      pending_d   = '0;
      commit_d    = '0;
      idx_d       = '0;
      frame_cnt_d = '0;
      sticky_d    = 1'b0;
      phase_d     = 2'd0;
      event_d     = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_now_q  <= 1'b0;
      sync_prev_q <= 1'b0;
      tick_q      <= 1'b0;
      sticky_q    <= 1'b0;
      alive_q     <= '1;
      pending_q   <= '0;
      commit_q    <= '0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      phase_q     <= 2'd0;
      score_q     <= '0;
      event_q     <= 1'b0;
    end else begin
      sync_now_q  <= frame_clk;
      sync_prev_q <= sync_now_q;
      tick_q      <= tick_d;
      sticky_q    <= sticky_d;
      alive_q     <= alive_d;
      pending_q   <= pending_d;
      commit_q    <= commit_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
      score_q     <= score_d;
      event_q     <= event_d;
    end
  end

  // Output logic
  always_comb begin
    coin_alive    = alive_q;
    coin_phase    = phase_q;
    score         = score_q;
    coin_event    = event_q;
    all_collected = ~|alive_q;
  end

endmodule

// File: tb/tb_coin_scheduler.sv
// Directed bench for coin_scheduler (4 coins, 2 frames per phase); a second
// instance with a 2-bit score shares the stimulus to exercise saturation.
module tb_coin_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       level_restart = 1'b0;
  logic [3:0] mario_hit = 4'b0000;

  logic [3:0] coin_alive, sat_alive;
  logic [1:0] coin_phase, sat_phase;
  logic [3:0] score;
  logic [1:0] sat_score;
  logic       coin_event, sat_event;
  logic       all_collected, sat_all;

  int checks = 0;
  int errors = 0;

  coin_scheduler #(.NUM_COINS(4), .SCORE_W(4), .PHASE_FRAMES(2)) dut (
    .Clk(clk), .Reset(reset), .frame_clk(frame_clk), .level_restart(level_restart),
    .mario_hit(mario_hit), .coin_alive(coin_alive), .coin_phase(coin_phase),
    .score(score), .coin_event(coin_event), .all_collected(all_collected)
  );

  coin_scheduler #(.NUM_COINS(4), .SCORE_W(2), .PHASE_FRAMES(2)) dut_sat (
    .Clk(clk), .Reset(reset), .frame_clk(frame_clk), .level_restart(level_restart),
    .mario_hit(mario_hit), .coin_alive(sat_alive), .coin_phase(sat_phase),
    .score(sat_score), .coin_event(sat_event), .all_collected(sat_all)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Rising frame_clk now; returns just after edge T (SCAN entry).
  task automatic frame_tick_req();
    frame_clk = 1'b1;
    step(1);
    frame_clk = 1'b0;
    step(2);
  endtask

  // From just after T, check coin_event at T+1..T+4 against a per-coin mask.
  task automatic scan_expect(input string tag, input logic [3:0] ev_mask);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check($sformatf("%s_event%0d", tag, i), coin_event, ev_mask[i]);
    end
    step(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
  endtask

  logic [1:0] phase_seq [7] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1};

  initial begin
    // Reset state
    step(2);
    reset = 1'b0;
    step(1);
    check("rst_alive", coin_alive, 4'b1111);
    check("rst_score", score, 0);
    check("rst_phase", coin_phase, 0);
    check("rst_event", coin_event, 0);
    check("rst_allc", all_collected, 0);

    // Single hit on coin 2
    mario_hit = 4'b0100;
    step(3);
    mario_hit = 4'b0000;
    frame_tick_req();
    check("single_phase_T", coin_phase, 0);
    step(2);
    check("single_alive_T2", coin_alive, 4'b1111);
    check("single_event_T2", coin_event, 0);
    step(1);
    check("single_alive_T3", coin_alive, 4'b1011);
    check("single_score_T3", score, 1);
    check("single_event_T3", coin_event, 1);
    step(1);
    check("single_event_T4", coin_event, 0);
    step(1);
    frame_tick_req();
    check("single_phase_2nd", coin_phase, 1);
    scan_expect("single2", 4'b0000);
    check("single2_alive", coin_alive, 4'b1011);
    check("single2_score", score, 1);

    // Multi-hit then duplicate hits on already-dead coins
    do_reset();
    mario_hit = 4'b1001;
    step(2);
    mario_hit = 4'b0000;
    frame_tick_req();
    scan_expect("multi", 4'b1001);
    check("multi_score", score, 2);
    mario_hit = 4'b1001;
    step(2);
    mario_hit = 4'b0000;
    frame_tick_req();
    scan_expect("dup", 4'b0000);
    check("dup_score", score, 2);
    check("dup_alive", coin_alive, 4'b0110);

    // Hit and tick both land during SCAN at T+2
    do_reset();
    frame_clk = 1'b1;
    step(1);
    frame_clk = 1'b0;
    step(1);
    frame_clk = 1'b1;
    step(1);                 // after T
    frame_clk = 1'b0;
    step(1);                 // after T+1
    mario_hit = 4'b0010;
    step(1);                 // after T+2
    mario_hit = 4'b0000;
    for (int i = 3; i <= 8; i++) begin
      step(1);
      check($sformatf("sticky_event_T%0d", i), coin_event, (i == 7) ? 1 : 0);
    end
    check("sticky_score", score, 1);
    check("sticky_alive", coin_alive, 4'b1101);
    check("sticky_phase", coin_phase, 1);

    // Collect everything, saturation, phase sequence, restart
    do_reset();
    mario_hit = 4'b1111;
    step(1);
    mario_hit = 4'b0000;
    frame_tick_req();
    check("all_phase_t1", coin_phase, 0);
    scan_expect("all", 4'b1111);
    check("all_score", score, 4);
    check("sat_score", sat_score, 3);
    check("all_collected", all_collected, 1);
    check("all_alive", coin_alive, 4'b0000);
    for (int i = 0; i < 7; i++) begin
      frame_tick_req();
      check($sformatf("phase_t%0d", i + 2), coin_phase, phase_seq[i]);
      step(5);
    end
    level_restart = 1'b1;
    step(1);
    level_restart = 1'b0;
    check("rst_lvl_alive", coin_alive, 4'b1111);
    check("rst_lvl_score", score, 4);
    check("rst_lvl_sat", sat_score, 3);
    check("rst_lvl_phase", coin_phase, 0);
    check("rst_lvl_allc", all_collected, 0);

    // Reset sampled at T+2 aborts the scan
    do_reset();
    mario_hit = 4'b1111;
    step(1);
    mario_hit = 4'b0000;
    frame_tick_req();
    step(1);                 // after T+1
    check("abort_alive_T1", coin_alive, 4'b1110);
    check("abort_score_T1", score, 1);
    reset = 1'b1;
    step(1);                 // after T+2
    reset = 1'b0;
    check("abort_alive", coin_alive, 4'b1111);
    check("abort_score", score, 0);
    check("abort_event", coin_event, 0);
    check("abort_phase", coin_phase, 0);
    check("abort_allc", all_collected, 0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check($sformatf("abort_post_event%0d", i), coin_event, 0);
    end
    check("abort_post_alive", coin_alive, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
